rx_sr_ctrl: RTL and testbench



---
 rtl/rx_sr_ctrl.sv | 129 ++++++++++++
 tb/tb_rx_sr_ctrl.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_sr_ctrl.sv
// Receive shift-register sequencer: counts 32-bit words into blocks and hands blocks downstream.
// Optional partial-block idle timeout enabled by defining RX_SR_CTRL_TIMEOUT_EN.
module rx_sr_ctrl #(
  parameter int unsigned WORDS_PER_BLOCK = 4,
  parameter int unsigned CNT_W           = 3,
  parameter int unsigned BLK_CNT_W       = 16,
  parameter int unsigned TIMEOUT_CYCLES  = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 abort,
  input  logic                 word_valid,
  output logic                 word_ready,
  output logic                 shift_enable,
  output logic                 block_valid,
  input  logic                 block_ready,
  output logic [CNT_W-1:0]     word_count,
  output logic [BLK_CNT_W-1:0] blocks_rcvd,
  output logic                 timeout_err
);

  typedef enum logic [1:0] {StEmpty, StFill, StFull} state_e;

  localparam logic [CNT_W-1:0] CntFull = CNT_W'(WORDS_PER_BLOCK);

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d, cnt_inc;
  logic [BLK_CNT_W-1:0]   blk_q, blk_d;
  logic                   accept;
  logic                   idle_expired;

  // In FULL a new word is only taken when the held block leaves in the same cycle.
  assign word_ready   = ~rst & ~abort & ((state_q != StFull) | block_ready);
  assign accept       = word_valid & word_ready;
  assign shift_enable = accept;
  assign cnt_inc      = cnt_q + 1'b1;

`ifdef RX_SR_CTRL_TIMEOUT_EN
  localparam int unsigned      IdleW    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IdleW-1:0] IdleLast = IdleW'(TIMEOUT_CYCLES - 1);

  logic [IdleW-1:0] idle_q, idle_d;
  logic             err_q;

  always_comb begin
    idle_d       = '0;
    idle_expired = 1'b0;
    if (!abort && (state_q == StFill) && !accept) begin
      if (idle_q == IdleLast) begin
        idle_expired = 1'b1;
      end else begin
        idle_d = idle_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idle_q <= '0;
      err_q  <= 1'b0;
    end else begin
      idle_q <= idle_d;
      err_q  <= idle_expired;
    end
  end

  assign timeout_err = err_q;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign idle_expired       = 1'b0;
  assign timeout_err        = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    blk_d   = blk_q;
    if (abort) begin
      state_d = StEmpty;
      cnt_d   = '0;
    end else begin
      case (state_q)
        StEmpty, StFill: begin
          if (accept) begin
            cnt_d   = cnt_inc;
            state_d = (cnt_inc == CntFull) ? StFull : StFill;
          end else if (idle_expired) begin
            cnt_d   = '0;
            state_d = StEmpty;
          end
        end
        StFull: begin
          if (block_ready) begin
            blk_d = blk_q + 1'b1;
            if (accept) begin
              cnt_d   = CNT_W'(1);
              state_d = StFill;
            end else begin
              cnt_d   = '0;
              state_d = StEmpty;
            end
          end
        end
        default: begin
          state_d = StEmpty;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StEmpty;
      cnt_q   <= '0;
      blk_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      blk_q   <= blk_d;
    end
  end

  assign word_count  = cnt_q;
  assign block_valid = (state_q == StFull);
  assign blocks_rcvd = blk_q;

endmodule

// File: tb/tb_rx_sr_ctrl.sv
// Self-checking bench for rx_sr_ctrl: expected post-edge state is queued when stimulus is driven
// and popped after the clock edge.
module tb_rx_sr_ctrl;

  localparam int unsigned WPB = 4;
  localparam int unsigned CW  = 3;
  localparam int unsigned BW  = 16;
  localparam int unsigned TO  = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          abort = 1'b0;
  logic          word_valid = 1'b0;
  logic          word_ready;
  logic          shift_enable;
  logic          block_valid;
  logic          block_ready = 1'b0;
  logic [CW-1:0] word_count;
  logic [BW-1:0] blocks_rcvd;
  logic          timeout_err;

  typedef struct packed {
    logic [CW-1:0] cnt;
    logic          bv;
    logic [BW-1:0] blk;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   m_cnt    = 0;
  int   m_blk    = 0;
  logic exp_rdy, exp_shift;

  rx_sr_ctrl #(
    .WORDS_PER_BLOCK(WPB),
    .CNT_W          (CW),
    .BLK_CNT_W      (BW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .abort       (abort),
    .word_valid  (word_valid),
    .word_ready  (word_ready),
    .shift_enable(shift_enable),
    .block_valid (block_valid),
    .block_ready (block_ready),
    .word_count  (word_count),
    .blocks_rcvd (blocks_rcvd),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Drives one cycle of inputs, computes expected handshake and queues expected next state.
  task automatic drive(input logic wv, input logic br, input logic ab);
    logic rdy, acc;
    exp_t e;
    word_valid  = wv;
    block_ready = br;
    abort       = ab;
    rdy = !ab && ((m_cnt != WPB) || br);
    acc = wv && rdy;
    exp_rdy   = rdy;
    exp_shift = acc;
    if (ab) begin
      m_cnt = 0;
    end else if (m_cnt == WPB) begin
      if (br) begin
        m_blk = (m_blk + 1) % 65536;
        m_cnt = acc ? 1 : 0;
      end
    end else if (acc) begin
      m_cnt = m_cnt + 1;
    end
    e.cnt = CW'(m_cnt);
    e.bv  = (m_cnt == WPB);
    e.blk = BW'(m_blk);
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #1;
    n_checks++;
    if (word_count !== 0 || block_valid !== 0 || blocks_rcvd !== 0 || timeout_err !== 0 ||
        word_ready !== 0) begin
      n_fail++;
      $display("FAIL reset_values got cnt=%0d bv=%b blk=%0d err=%b rdy=%b want 0 0 0 0 0",
               word_count, block_valid, blocks_rcvd, timeout_err, word_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    tick();
  endtask

  task automatic test_fill();
    exp_t e;
    for (int i = 0; i < WPB + 2; i++) begin
      drive(1'b1, 1'b0, 1'b0);
      #1;
      n_checks++;
      if (word_ready !== exp_rdy || shift_enable !== exp_shift) begin
        n_fail++;
        $display("FAIL fill_hs[%0d] got rdy=%b sh=%b want rdy=%b sh=%b",
                 i, word_ready, shift_enable, exp_rdy, exp_shift);
      end
      tick();
      e = sb.pop_front();
      n_checks++;
      if (word_count !== e.cnt || block_valid !== e.bv || blocks_rcvd !== e.blk) begin
        n_fail++;
        $display("FAIL fill_state[%0d] got cnt=%0d bv=%b blk=%0d want cnt=%0d bv=%b blk=%0d",
                 i, word_count, block_valid, blocks_rcvd, e.cnt, e.bv, e.blk);
      end
    end
  endtask

  // Handoff and accept in the same cycle, then refill and drain with no new word.
  task automatic test_back_to_back();
    exp_t e;
    logic wv_tab[5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic br_tab[5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 5; i++) begin
      drive(wv_tab[i], br_tab[i], 1'b0);
      #1;
      n_checks++;
      if (word_ready !== exp_rdy || shift_enable !== exp_shift) begin
        n_fail++;
        $display("FAIL b2b_hs[%0d] got rdy=%b sh=%b want rdy=%b sh=%b",
                 i, word_ready, shift_enable, exp_rdy, exp_shift);
      end
      tick();
      e = sb.pop_front();
      n_checks++;
      if (word_count !== e.cnt || block_valid !== e.bv || blocks_rcvd !== e.blk) begin
        n_fail++;
        $display("FAIL b2b_state[%0d] got cnt=%0d bv=%b blk=%0d want cnt=%0d bv=%b blk=%0d",
                 i, word_count, block_valid, blocks_rcvd, e.cnt, e.bv, e.blk);
      end
    end
  endtask

  task automatic test_stream();
    exp_t e;
    int   blk_start;
    blk_start = m_blk;
    for (int i = 0; i < 13; i++) begin
      drive(i < 12, 1'b1, 1'b0);
      #1;
      n_checks++;
      if (word_ready !== 1'b1 || shift_enable !== exp_shift) begin
        n_fail++;
        $display("FAIL stream_hs[%0d] got rdy=%b sh=%b want rdy=1 sh=%b",
                 i, word_ready, shift_enable, exp_shift);
      end
      tick();
      e = sb.pop_front();
      n_checks++;
      if (word_count !== e.cnt || block_valid !== e.bv || blocks_rcvd !== e.blk) begin
        n_fail++;
        $display("FAIL stream_state[%0d] got cnt=%0d bv=%b blk=%0d want cnt=%0d bv=%b blk=%0d",
                 i, word_count, block_valid, blocks_rcvd, e.cnt, e.bv, e.blk);
      end
    end
    n_checks++;
    if (blocks_rcvd !== BW'(blk_start + 3)) begin
      n_fail++;
      $display("FAIL stream_blocks got %0d want %0d", blocks_rcvd, blk_start + 3);
    end
  endtask

  // Abort mid-fill with a word offered, refill, then abort a full block while it is requested.
  task automatic test_abort();
    exp_t e;
    logic wv_tab[9] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic br_tab[9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic ab_tab[9] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 9; i++) begin
      drive(wv_tab[i], br_tab[i], ab_tab[i]);
      #1;
      n_checks++;
      if (word_ready !== exp_rdy || shift_enable !== exp_shift) begin
        n_fail++;
        $display("FAIL abort_hs[%0d] got rdy=%b sh=%b want rdy=%b sh=%b",
                 i, word_ready, shift_enable, exp_rdy, exp_shift);
      end
      tick();
      e = sb.pop_front();
      n_checks++;
      if (word_count !== e.cnt || block_valid !== e.bv || blocks_rcvd !== e.blk) begin
        n_fail++;
        $display("FAIL abort_state[%0d] got cnt=%0d bv=%b blk=%0d want cnt=%0d bv=%b blk=%0d",
                 i, word_count, block_valid, blocks_rcvd, e.cnt, e.bv, e.blk);
      end
    end
  endtask

  task automatic test_async_reset();
    exp_t e;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 1'b0);
      tick();
      e = sb.pop_front();
      n_checks++;
      if (word_count !== e.cnt) begin
        n_fail++;
        $display("FAIL areset_pre[%0d] got cnt=%0d want %0d", i, word_count, e.cnt);
      end
    end
    word_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if (word_count !== 0 || block_valid !== 0 || blocks_rcvd !== 0 || word_ready !== 0) begin
      n_fail++;
      $display("FAIL areset_now got cnt=%0d bv=%b blk=%0d rdy=%b want 0 0 0 0",
               word_count, block_valid, blocks_rcvd, word_ready);
    end
    m_cnt = 0;
    m_blk = 0;
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    tick();
    for (int i = 0; i < WPB + 1; i++) begin
      drive(i < WPB, i == WPB, 1'b0);
      tick();
      e = sb.pop_front();
      n_checks++;
      if (word_count !== e.cnt || block_valid !== e.bv || blocks_rcvd !== e.blk) begin
        n_fail++;
        $display("FAIL areset_post[%0d] got cnt=%0d bv=%b blk=%0d want cnt=%0d bv=%b blk=%0d",
                 i, word_count, block_valid, blocks_rcvd, e.cnt, e.bv, e.blk);
      end
    end
  endtask

  task automatic test_timeout();
    exp_t e;
    drive(1'b1, 1'b0, 1'b0);
    tick();
    e = sb.pop_front();
    n_checks++;
    if (word_count !== e.cnt) begin
      n_fail++;
      $display("FAIL timeout_first got cnt=%0d want %0d", word_count, e.cnt);
    end
    word_valid = 1'b0;
`ifdef RX_SR_CTRL_TIMEOUT_EN
    begin
      int hit = 0;
      for (int i = 1; i <= 20 && hit == 0; i++) begin
        tick();
        if (timeout_err === 1'b1) hit = i;
      end
      n_checks++;
      if (hit != TO || word_count !== 0) begin
        n_fail++;
        $display("FAIL timeout_pulse got at=%0d cnt=%0d want at=%0d cnt=0", hit, word_count, TO);
      end
      tick();
      n_checks++;
      if (timeout_err !== 1'b0) begin
        n_fail++;
        $display("FAIL timeout_width got err=%b want 0", timeout_err);
      end
      m_cnt = 0;
    end
`else
    for (int i = 0; i < 100; i++) begin
      tick();
      n_checks++;
      if (word_count !== 1 || timeout_err !== 1'b0) begin
        n_fail++;
        $display("FAIL hold_partial[%0d] got cnt=%0d err=%b want cnt=1 err=0",
                 i, word_count, timeout_err);
      end
    end
    drive(1'b0, 1'b0, 1'b1);
    tick();
    e = sb.pop_front();
    n_checks++;
    if (word_count !== e.cnt) begin
      n_fail++;
      $display("FAIL hold_clear got cnt=%0d want %0d", word_count, e.cnt);
    end
`endif
    abort = 1'b0;
  endtask

  initial begin
    test_reset();
    test_fill();
    test_back_to_back();
    test_stream();
    test_abort();
    test_async_reset();
    test_timeout();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
